// File: rtl/nrf_spi_responder.sv
// nRF24L01-style SPI mode-0 responder: STATUS on every command byte, a 32x8 register
// file, a write-payload sink and a read-payload source, all oversampled on clk_in.
module nrf_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_RST  = 8'h0E
) (
  input  logic       clk_in,
  input  logic       key0_rst,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  input  logic [2:0] irq_set,
  output logic       irq_n,
  output logic [7:0] reg_config,
  output logic [7:0] reg_rf_ch,
  output logic [7:0] tx_pl_data,
  output logic       tx_pl_valid,
  input  logic [7:0] rx_pl_data,
  output logic       rx_pl_pop,
  output logic       cmd_done
);

  typedef enum logic [2:0] {IDLE, CMD, RD_REG, WR_REG, WR_PL, RD_PL, IGNORE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic                   sck_d, csn_d;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_rise, csn_rise, csn_fall, shift_rise, byte_done;

  logic [7:0]       shift_out;
  logic [6:0]       shift_in;
  logic [7:0]       in_byte;
  logic [2:0]       bit_cnt;
  logic [4:0]       addr, rd_sel;
  logic             got_byte;
  logic [2:0]       status_irq, status_clr;
  logic [7:0]       status_val, rd_data;
  logic [31:0][7:0] regs;
  logic             wr_allowed;

  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign csn_s      = csn_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign csn_rise   = csn_s & ~csn_d;
  assign csn_fall   = ~csn_s & csn_d;
  assign shift_rise = sck_rise & ~csn_s & (state != IDLE);
  assign byte_done  = shift_rise & (bit_cnt == 3'd7);
  assign in_byte    = {shift_in, mosi_s};

  // STATUS is synthesised: only the three interrupt flags are stored.
  assign status_val = {1'b0, status_irq, 3'b111, 1'b0};
  assign rd_sel     = (state == CMD) ? in_byte[4:0] : addr;
  assign rd_data    = (rd_sel == 5'h07) ? status_val : regs[rd_sel];
  assign wr_allowed = (addr != 5'h07) && (addr != 5'h08) && (addr != 5'h09) && (addr != 5'h17);
  assign status_clr = (byte_done && state == WR_REG && addr == 5'h07) ? in_byte[6:4] : '0;

  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (csn_rise) begin
      state_next = IDLE;
    end else if (csn_fall) begin
      state_next = CMD;
    end else if (byte_done && state == CMD) begin
      casez (in_byte)
        8'b000?????: state_next = RD_REG;
        8'b001?????: state_next = WR_REG;
        8'hA0:       state_next = WR_PL;
        8'h61:       state_next = RD_PL;
        default:     state_next = IGNORE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge key0_rst) begin
    if (!key0_rst) begin
      shift_out   <= '0;
      shift_in    <= '0;
      bit_cnt     <= '0;
      addr        <= '0;
      got_byte    <= 1'b0;
      tx_pl_data  <= '0;
      tx_pl_valid <= 1'b0;
      rx_pl_pop   <= 1'b0;
      cmd_done    <= 1'b0;
      status_irq  <= STATUS_RST[6:4];
      regs        <= '0;
      regs[0]     <= 8'h08;
      regs[1]     <= 8'h3F;
      regs[2]     <= 8'h03;
      regs[3]     <= 8'h03;
      regs[4]     <= 8'h03;
      regs[5]     <= 8'h02;
      regs[6]     <= 8'h0E;
    end else begin
      tx_pl_valid <= 1'b0;
      rx_pl_pop   <= 1'b0;
      cmd_done    <= 1'b0;
      // set has priority over a same-cycle write-1-to-clear
      status_irq  <= (status_irq & ~status_clr) | irq_set;
      if (csn_rise) begin
        bit_cnt   <= '0;
        cmd_done  <= got_byte;
        got_byte  <= 1'b0;
        shift_out <= '0;
      end else if (csn_fall) begin
        shift_out <= status_val;
        bit_cnt   <= '0;
        got_byte  <= 1'b0;
      end else if (shift_rise) begin
        shift_in  <= in_byte[6:0];
        shift_out <= {shift_out[6:0], 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          got_byte  <= 1'b1;
          shift_out <= '0;
          case (state)
            CMD: begin
              addr <= in_byte[4:0];
              if (state_next == RD_REG) begin
                shift_out <= rd_data;
              end else if (state_next == RD_PL) begin
                shift_out <= rx_pl_data;
                rx_pl_pop <= 1'b1;
              end
            end
            RD_REG: shift_out <= rd_data;
            WR_REG: if (wr_allowed) regs[addr] <= in_byte;
            WR_PL: begin
              tx_pl_data  <= in_byte;
              tx_pl_valid <= 1'b1;
            end
            RD_PL: begin
              shift_out <= rx_pl_data;
              rx_pl_pop <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign miso       = ~csn & (state != IDLE) & shift_out[7];
  assign irq_n      = ~|(status_irq & ~regs[0][6:4]);
  assign reg_config = regs[0];
  assign reg_rf_ch  = regs[5];

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder: a bit-banged mode-0 master with a scoreboard
// of expected MISO bytes and expected TX payload bytes.
module tb_nrf_spi_responder;

  logic       clk_in = 1'b0;
  logic       key0_rst = 1'b0;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic [2:0] irq_set = '0;
  logic       miso, irq_n, tx_pl_valid, rx_pl_pop, cmd_done;
  logic [7:0] reg_config, reg_rf_ch, tx_pl_data, rx_pl_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tx_cnt = 0;
  int pop_cnt = 0;
  int rx_idx = 0;
  int done_before;
  logic [7:0] miso_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] tx_exp;
  logic [7:0] rx_src [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rx;

  nrf_spi_responder #(.SYNC_STAGES(2), .STATUS_RST(8'h0E)) dut (
    .clk_in(clk_in), .key0_rst(key0_rst), .sck(sck), .csn(csn), .mosi(mosi), .miso(miso),
    .irq_set(irq_set), .irq_n(irq_n), .reg_config(reg_config), .reg_rf_ch(reg_rf_ch),
    .tx_pl_data(tx_pl_data), .tx_pl_valid(tx_pl_valid), .rx_pl_data(rx_pl_data),
    .rx_pl_pop(rx_pl_pop), .cmd_done(cmd_done)
  );

  always #10 clk_in = ~clk_in;

  assign rx_pl_data = rx_src[rx_idx % 4];

  always @(posedge clk_in) if (rx_pl_pop === 1'b1) rx_idx <= rx_idx + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (cmd_done === 1'b1) done_cnt++;
    if (rx_pl_pop === 1'b1) pop_cnt++;
    if (tx_pl_valid === 1'b1) begin
      tx_cnt++;
      if (tx_q.size() > 0) tx_exp = tx_q.pop_front();
      else                 tx_exp = 'x;
      check("tx_pl_data", tx_pl_data, tx_exp);
    end
  end

  task automatic spi_begin();
    csn = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic spi_end();
    repeat (2) @(negedge clk_in);
    csn  = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxd);
    rxd = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk_in);
      rxd[i] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk_in);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    miso_q.push_back(exp);
    spi_bits(tx, 8, got);
    check(tag, got, miso_q.pop_front());
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_miso", miso, 0);
    check("rst_irq_n", irq_n, 1);
    check("rst_strobes", {tx_pl_valid, rx_pl_pop, cmd_done}, 0);
    check("rst_tx_pl_data", tx_pl_data, 8'h00);
    check("rst_config", reg_config, 8'h08);
    check("rst_rf_ch", reg_rf_ch, 8'h02);
    key0_rst = 1'b1;
    repeat (3) @(negedge clk_in);

    spi_begin(); xfer(8'hFF, 8'h0E, "t1_status"); spi_end();
    check("t1_cmd_done", done_cnt, 1);
    check("t1_no_tx", tx_cnt, 0);
    check("t1_no_pop", pop_cnt, 0);

    spi_begin(); xfer(8'h25, 8'h0E, "t2_wr_cmd"); xfer(8'h4C, 8'h00, "t2_wr_data"); spi_end();
    check("t2_rf_ch", reg_rf_ch, 8'h4C);
    spi_begin();
    xfer(8'h05, 8'h0E, "t2_rd_cmd");
    xfer(8'hFF, 8'h4C, "t2_rd_byte1");
    xfer(8'hFF, 8'h4C, "t2_rd_byte2");
    spi_end();
    check("t2_cmd_done", done_cnt, 3);

    @(negedge clk_in); irq_set = 3'b100;
    @(negedge clk_in); irq_set = 3'b000;
    repeat (2) @(negedge clk_in);
    check("t3_irq_low", irq_n, 0);
    spi_begin(); xfer(8'hFF, 8'h4E, "t3_status_set"); spi_end();
    spi_begin(); xfer(8'h27, 8'h4E, "t3_w1c_cmd"); xfer(8'h40, 8'h00, "t3_w1c_data"); spi_end();
    check("t3_irq_high", irq_n, 1);
    spi_begin(); xfer(8'hFF, 8'h0E, "t3_status_clr"); spi_end();

    spi_begin();
    xfer(8'hA0, 8'h0E, "t4_cmd");
    tx_q.push_back(8'hA5); xfer(8'hA5, 8'h00, "t4_pl0");
    tx_q.push_back(8'h5A); xfer(8'h5A, 8'h00, "t4_pl1");
    tx_q.push_back(8'h3C); xfer(8'h3C, 8'h00, "t4_pl2");
    spi_end();
    check("t4_tx_count", tx_cnt, 3);
    check("t4_tx_queue_empty", tx_q.size(), 0);

    spi_begin();
    xfer(8'h61, 8'h0E, "t5_cmd");
    xfer(8'hFF, 8'h11, "t5_rx0");
    check("t5_pop_count", pop_cnt, 2);
    xfer(8'hFF, 8'h22, "t5_rx1");
    spi_end();

    done_before = done_cnt;
    spi_begin(); xfer(8'h20, 8'h0E, "t6_cmd"); spi_bits(8'h00, 5, rx); spi_end();
    check("t6_config_kept", reg_config, 8'h08);
    check("t6_one_cmd_done", done_cnt - done_before, 1);

    @(negedge clk_in); irq_set = 3'b001;
    @(negedge clk_in); irq_set = 3'b000;
    spi_begin(); xfer(8'h25, 8'h1E, "t6_rst_cmd"); spi_bits(8'h77, 3, rx);
    key0_rst = 1'b0;
    #1;
    check("t6_rst_rf_ch", reg_rf_ch, 8'h02);
    check("t6_rst_config", reg_config, 8'h08);
    check("t6_rst_irq_n", irq_n, 1);
    check("t6_rst_miso", miso, 0);
    check("t6_rst_tx_pl_data", tx_pl_data, 8'h00);
    sck = 1'b0; csn = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk_in);
    key0_rst = 1'b1;
    repeat (3) @(negedge clk_in);
    spi_begin(); xfer(8'hFF, 8'h0E, "t6_post_rst_status"); spi_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
